// File: rtl/sram_seq_ring_ctrl.sv
// Controller for the SRAM holding target sequence T: packed loads, in-order ring reads and
// writebacks for the PE array, and an init sweep that clears score state while keeping symbols.
module sram_seq_ring_ctrl #(
    parameter int  WORD_W       = 256,
    parameter int  ADDR_W       = 10,
    parameter int  SYM_PER_WORD = 7,
    parameter int  SYM_W        = 2,
    parameter int  FIELD_W      = 36,
    parameter int  HDR_W        = 4,
    parameter int  RD_LAT       = 1,
    localparam int CNT_W        = $clog2(SYM_PER_WORD + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_load_valid,
    input  logic                            i_load_last,
    input  logic [CNT_W-1:0]                i_load_cnt,
    input  logic [SYM_PER_WORD*SYM_W-1:0]   i_load_sym,
    output logic                            o_load_ready,
    input  logic                            i_init,
    input  logic                            i_req_valid,
    output logic                            o_req_ready,
    output logic                            o_rsp_valid,
    output logic [WORD_W-1:0]               o_rsp_data,
    input  logic                            i_wb_valid,
    input  logic [WORD_W-1:0]               i_wb_data,
    output logic                            o_wb_ready,
    output logic                            o_busy,
    output logic [ADDR_W+CNT_W-1:0]         o_t_size,
    output logic [ADDR_W:0]                 o_num_words,
    output logic                            o_overflow,
    output logic                            o_sram_cen,
    output logic                            o_sram_wen,
    output logic [ADDR_W-1:0]               o_sram_a,
    output logic [WORD_W-1:0]               o_sram_d,
    input  logic [WORD_W-1:0]               i_sram_q
);
    localparam int BODY_W = WORD_W - HDR_W;
    localparam int WAIT_W = $clog2(RD_LAT + 1);
    localparam int TS_W   = ADDR_W + CNT_W;
    localparam int NW_W   = ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, LOAD, INIT_RD, INIT_WAIT, INIT_WR} state_t;

    state_t              state_reg, state_next;
    logic [NW_W-1:0]     num_words_reg, num_words_next;
    logic [TS_W-1:0]     t_size_reg, t_size_next;
    logic [CNT_W-1:0]    last_cnt_reg, last_cnt_next;
    logic                overflow_reg, overflow_next;
    logic [ADDR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0]   init_idx_reg, init_idx_next;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic                cen_reg, cen_next;
    logic                wen_reg, wen_next;
    logic [ADDR_W-1:0]   a_reg, a_next;
    logic [WORD_W-1:0]   d_reg, d_next;
    logic [RD_LAT:0]     rd_pipe_reg, rd_pipe_next;
    logic                rsp_valid_reg;
    logic [WORD_W-1:0]   rsp_data_reg;

    logic                load_ready, req_ready, wb_ready;
    logic                load_fire, rd_issue;
    logic [BODY_W-1:0]   load_body;
    logic [WORD_W-1:0]   keep_mask;
    logic [NW_W-1:0]     last_idx, base_words;
    logic [ADDR_W-1:0]   load_addr;
    logic                load_full, load_store, ring_nonempty;
    logic                wb_hdr_unused;

    function automatic logic [HDR_W-1:0] make_hdr(input logic [CNT_W-1:0] cnt);
        return {1'b1, (HDR_W-1)'(cnt)};
    endfunction

    // Each field carries its symbol in the top bits; everything below is PE score state.
    assign keep_mask[WORD_W-1 -: HDR_W] = '1;
    generate
        for (genvar gi = 0; gi < SYM_PER_WORD; gi++) begin : g_field
            localparam int HI = BODY_W - 1 - gi * FIELD_W;
            assign load_body[HI -: FIELD_W] =
                {i_load_sym[(SYM_PER_WORD-gi)*SYM_W-1 -: SYM_W], {(FIELD_W-SYM_W){1'b0}}};
            assign keep_mask[HI -: FIELD_W] = {{SYM_W{1'b1}}, {(FIELD_W-SYM_W){1'b0}}};
        end
    endgenerate

    assign wb_hdr_unused = ^i_wb_data[WORD_W-1 -: HDR_W];
    assign ring_nonempty = (num_words_reg != '0);
    assign last_idx      = num_words_reg - NW_W'(1);
    assign base_words    = (state_reg == IDLE) ? '0 : num_words_reg;
    assign load_addr     = base_words[ADDR_W-1:0];
    assign load_full     = &load_addr;
    assign load_store    = ~(i_load_last & (i_load_cnt == '0));

    always_comb begin
        state_next     = state_reg;
        num_words_next = num_words_reg;
        t_size_next    = t_size_reg;
        last_cnt_next  = last_cnt_reg;
        overflow_next  = overflow_reg;
        rd_ptr_next    = rd_ptr_reg;
        wr_ptr_next    = wr_ptr_reg;
        init_idx_next  = init_idx_reg;
        wait_cnt_next  = wait_cnt_reg;
        cen_next       = 1'b1;
        wen_next       = 1'b1;
        a_next         = a_reg;
        d_next         = d_reg;
        load_ready     = 1'b0;
        req_ready      = 1'b0;
        wb_ready       = 1'b0;
        load_fire      = 1'b0;
        rd_issue       = 1'b0;

        case (state_reg)
            IDLE: begin
                load_ready = ~i_init;
                wb_ready   = ~i_init & ring_nonempty;
                req_ready  = wb_ready & ~i_wb_valid;
                if (i_init) begin
                    if (ring_nonempty) begin
                        state_next    = INIT_RD;
                        init_idx_next = '0;
                        rd_ptr_next   = '0;
                        wr_ptr_next   = '0;
                    end
                end else if (i_load_valid) begin
                    load_fire = 1'b1;
                end else if (i_wb_valid && wb_ready) begin
                    cen_next    = 1'b0;
                    wen_next    = 1'b0;
                    a_next      = wr_ptr_reg;
                    d_next      = {make_hdr(({1'b0, wr_ptr_reg} == last_idx) ? last_cnt_reg : '0),
                                   i_wb_data[BODY_W-1:0]};
                    wr_ptr_next = ({1'b0, wr_ptr_reg} == last_idx) ? '0 : wr_ptr_reg + ADDR_W'(1);
                end else if (i_req_valid && req_ready) begin
                    cen_next    = 1'b0;
                    a_next      = rd_ptr_reg;
                    rd_issue    = 1'b1;
                    rd_ptr_next = ({1'b0, rd_ptr_reg} == last_idx) ? '0 : rd_ptr_reg + ADDR_W'(1);
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                load_fire  = i_load_valid;
            end
            INIT_RD: begin
                cen_next      = 1'b0;
                a_next        = init_idx_reg;
                wait_cnt_next = '0;
                state_next    = INIT_WAIT;
            end
            INIT_WAIT: begin
                wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                if (wait_cnt_reg == WAIT_W'(RD_LAT - 1))
                    state_next = INIT_WR;
            end
            INIT_WR: begin
                cen_next = 1'b0;
                wen_next = 1'b0;
                a_next   = init_idx_reg;
                d_next   = i_sram_q & keep_mask;
                if ({1'b0, init_idx_reg} == last_idx) begin
                    state_next = IDLE;
                end else begin
                    init_idx_next = init_idx_reg + ADDR_W'(1);
                    state_next    = INIT_RD;
                end
            end
            default: state_next = IDLE;
        endcase

        // A beat taken in IDLE starts a fresh T; base_words is already zero in that case.
        if (load_fire) begin
            t_size_next   = ((state_reg == IDLE) ? '0 : t_size_reg) + TS_W'(i_load_cnt);
            overflow_next = (state_reg == IDLE) ? 1'b0 : overflow_reg;
            if (state_reg == IDLE) begin
                rd_ptr_next = '0;
                wr_ptr_next = '0;
            end
            if (i_load_last)
                last_cnt_next = load_store ? i_load_cnt :
                                ((base_words != '0) ? CNT_W'(SYM_PER_WORD) : '0);
            else
                last_cnt_next = load_full ? CNT_W'(SYM_PER_WORD) : '0;
            if (load_store) begin
                cen_next       = 1'b0;
                wen_next       = 1'b0;
                a_next         = load_addr;
                d_next         = {make_hdr(last_cnt_next), load_body};
                num_words_next = base_words + NW_W'(1);
            end else begin
                num_words_next = base_words;
            end
            if (!i_load_last && load_full)
                overflow_next = 1'b1;
            state_next = (i_load_last || load_full) ? IDLE : LOAD;
        end

        rd_pipe_next = {rd_pipe_reg[RD_LAT-1:0], rd_issue};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            num_words_reg <= '0;
            t_size_reg    <= '0;
            last_cnt_reg  <= '0;
            overflow_reg  <= 1'b0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            init_idx_reg  <= '0;
            wait_cnt_reg  <= '0;
            cen_reg       <= 1'b1;
            wen_reg       <= 1'b1;
            a_reg         <= '0;
            d_reg         <= '0;
            rd_pipe_reg   <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            num_words_reg <= num_words_next;
            t_size_reg    <= t_size_next;
            last_cnt_reg  <= last_cnt_next;
            overflow_reg  <= overflow_next;
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            init_idx_reg  <= init_idx_next;
            wait_cnt_reg  <= wait_cnt_next;
            cen_reg       <= cen_next;
            wen_reg       <= wen_next;
            a_reg         <= a_next;
            d_reg         <= d_next;
            rd_pipe_reg   <= rd_pipe_next;
            rsp_valid_reg <= rd_pipe_reg[RD_LAT];
            rsp_data_reg  <= rd_pipe_reg[RD_LAT] ? i_sram_q : '0;
        end
    end

    assign o_load_ready = load_ready;
    assign o_req_ready  = req_ready;
    assign o_wb_ready   = wb_ready;
    assign o_rsp_valid  = rsp_valid_reg;
    assign o_rsp_data   = rsp_data_reg;
    assign o_busy       = (state_reg != IDLE);
    assign o_t_size     = t_size_reg;
    assign o_num_words  = num_words_reg;
    assign o_overflow   = overflow_reg;
    assign o_sram_cen   = cen_reg;
    assign o_sram_wen   = wen_reg;
    assign o_sram_a     = a_reg;
    assign o_sram_d     = d_reg;
endmodule
